priority_decoder: RTL and testbench
===================================

Name: priority_decoder

Overview:
- Inverse companion to the 12-input priority encoder.
- Accepts a stream of 4-bit encoded indices over a valid/ready handshake and drives a registered one-hot 12-bit strobe.
- Each strobe is held for a programmable number of cycles.
- Also keeps a sticky OR-accumulation of every index received, and flags and counts out-of-range codes.
- Sits downstream of the encoder to re-expand its output into per-line enables (indicators, grants).

Parameters:
- N_OUT, 12: width of the one-hot output; legal codes are 0..N_OUT-1.
- CODE_W, 4: width of the input code; must satisfy 2**CODE_W >= N_OUT.
- HOLD_CYCLES, 3: number of cycles each decoded strobe stays asserted; legal range 1..255.
- ERR_W, 8: width of the saturating error counter.

Ports:
- clk  input  1  system clock; rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_code  input  CODE_W  encoded index.
- in_valid  input  1  in_code is valid this cycle.
- in_ready  output  1  block can accept a code this cycle.
- acc_clr  input  1  synchronous clear of the accumulation vector.
- out_onehot  output  N_OUT  registered one-hot strobe; all zero when idle.
- out_active  output  1  high while out_onehot is non-zero.
- acc_vec  output  N_OUT  sticky OR of all decoded one-hots since the last clear or reset.
- err_pulse  output  1  one-cycle pulse when an out-of-range code is accepted.
- err_count  output  ERR_W  saturating count of out-of-range codes.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, hold counter=0, out_onehot=0, out_active=0, acc_vec=0, err_pulse=0, err_count=0. in_ready is 0 while rst_n=0 and 1 in the first cycle after release.
- Reset asserted mid-hold: the strobe drops immediately and the pending count is lost.
- Accept: a code is accepted on any rising edge where in_valid && in_ready.
- in_ready = (state==IDLE) || (state==HOLD && cnt==0). Combinational from registered state only; it never depends on in_valid.
- States: IDLE and HOLD.
  - IDLE + valid legal accept -> HOLD. On the next edge out_onehot = 1<<in_code and cnt = HOLD_CYCLES-1. Latency is 1 cycle from accept to strobe.
  - HOLD with cnt>0 -> cnt decrements; out_onehot is unchanged.
  - HOLD with cnt==0 and no accept -> IDLE; out_onehot=0.
  - HOLD with cnt==0 and a legal accept -> stays in HOLD; out_onehot loads the new one-hot and cnt reloads. The result is back-to-back strobes with no zero gap.
- Throughput: one code per HOLD_CYCLES cycles.
- out_active = |out_onehot, taken from a register; it never glitches.
- Illegal code (in_code >= N_OUT, i.e. 12..15 by default):
  - It is accepted (consumed), and err_pulse=1 on the next cycle.
  - err_count increments and saturates at 2**ERR_W-1.
  - No strobe is produced and acc_vec is unchanged.
  - If this happens at cnt==0 in HOLD, the state goes to IDLE and out_onehot=0.
- acc_vec:
  - On each legal accept, acc_vec |= 1<<in_code, visible on the next cycle.
  - acc_clr=1 clears it on the next edge.
  - acc_clr coinciding with a legal accept leaves acc_vec = 1<<in_code only (clear first, then set).
- in_code is ignored whenever in_valid=0 or in_ready=0. A held in_valid with in_ready=0 must not cause double acceptance.
- HOLD_CYCLES=1: every cycle in HOLD has cnt==0, so the block accepts one code per cycle at full rate.

Test Plan:
- Reset, then in_code=5 with valid for 1 cycle (HOLD_CYCLES=3) -> out_onehot=12'h020 for exactly 3 cycles then 0; in_ready=0 during the first 2 hold cycles; acc_vec=12'h020.
- Codes 0, 11, 3 driven back-to-back with in_valid held high -> strobes 12'h001, 12'h800, 12'h008, each 3 cycles with no zero gap; acc_vec=12'h809.
- in_code=13 accepted -> err_pulse for 1 cycle, err_count=1, out_onehot stays 0, acc_vec unchanged. 300 illegal codes with ERR_W=8 -> err_count saturates at 255.
- acc_clr=1 on the same edge as accepting code 7 while acc_vec=12'h809 -> acc_vec=12'h080.
- rst_n pulled low in the 2nd cycle of a code-9 strobe -> out_onehot, acc_vec and err_count go to 0 immediately without a clock edge; the first accept after release decodes correctly.
- HOLD_CYCLES=1 build, codes 1, 2, 4 on consecutive cycles -> out_onehot = 12'h002, 12'h004, 12'h010 on consecutive cycles; in_ready stays high.

Source files
------------

// File: rtl/priority_decoder.sv
// Priority decoder: turns a stream of encoded indices into held one-hot strobes,
// keeps a sticky OR of every decoded line and counts out-of-range codes.
module priority_decoder #(
   parameter int unsigned N_OUT       = 12,
   parameter int unsigned CODE_W      = 4,
   parameter int unsigned HOLD_CYCLES = 3,
   parameter int unsigned ERR_W       = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [CODE_W-1:0] in_code,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              acc_clr,
   output logic [N_OUT-1:0]  out_onehot,
   output logic              out_active,
   output logic [N_OUT-1:0]  acc_vec,
   output logic              err_pulse,
   output logic [ERR_W-1:0]  err_count
);

   localparam int unsigned CNT_W = 8;
   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CODE_W:0]  N_OUT_C   = N_OUT[CODE_W:0];

   typedef enum logic {
      IDLE,
      HOLD
   } state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [N_OUT-1:0]   onehot_q, onehot_nxt;
   logic [N_OUT-1:0]   acc_q, acc_nxt;
   logic [N_OUT-1:0]   dec;
   logic               active_q;
   logic               errp_q, errp_nxt;
   logic [ERR_W-1:0]   errc_q, errc_nxt;
   logic               accept;
   logic               legal;

   // Gated by rst_n so nothing is offered while the block is held in reset.
   assign in_ready = rst_n && ((state == IDLE) || (cnt == '0));
   assign accept   = in_valid && in_ready;
   assign legal    = ({1'b0, in_code} < N_OUT_C);

   always_comb begin
      dec = '0;
      for (int unsigned i = 0; i < N_OUT; i++) begin
         if (in_code == i[CODE_W-1:0]) dec[i] = 1'b1;
      end
   end

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      onehot_nxt = onehot_q;
      errp_nxt   = 1'b0;
      errc_nxt   = errc_q;
      acc_nxt    = acc_clr ? '0 : acc_q;

      case (state)
         IDLE: begin
            if (accept && legal) begin
               state_nxt  = HOLD;
               cnt_nxt    = HOLD_LOAD;
               onehot_nxt = dec;
            end
         end
         HOLD: begin
            if (cnt != '0) begin
               cnt_nxt = cnt - 1'b1;
            end else if (accept && legal) begin
               cnt_nxt    = HOLD_LOAD;
               onehot_nxt = dec;
            end else begin
               state_nxt  = IDLE;
               onehot_nxt = '0;
            end
         end
         default: begin
            state_nxt  = IDLE;
            cnt_nxt    = '0;
            onehot_nxt = '0;
         end
      endcase

      // Clear is applied before the set so a coinciding accept survives.
      if (accept && legal) acc_nxt = acc_nxt | dec;

      if (accept && !legal) begin
         errp_nxt = 1'b1;
         if (errc_q != '1) errc_nxt = errc_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         onehot_q <= '0;
         active_q <= 1'b0;
         acc_q    <= '0;
         errp_q   <= 1'b0;
         errc_q   <= '0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         onehot_q <= onehot_nxt;
         active_q <= |onehot_nxt;
         acc_q    <= acc_nxt;
         errp_q   <= errp_nxt;
         errc_q   <= errc_nxt;
      end
   end

   assign out_onehot = onehot_q;
   assign out_active = active_q;
   assign acc_vec    = acc_q;
   assign err_pulse  = errp_q;
   assign err_count  = errc_q;

endmodule

// File: tb/tb_priority_decoder.sv
// Bench for priority_decoder: directed scenarios plus randomized traffic on a
// HOLD_CYCLES=3 and a HOLD_CYCLES=1 instance, both checked against a strobe-lifetime model.
module tb_priority_decoder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  code  [2];
   logic        valid [2];
   logic        clr   [2];
   logic        rdy   [2];
   logic [11:0] oh    [2];
   logic        act   [2];
   logic [11:0] accv  [2];
   logic        errp  [2];
   logic [7:0]  errc  [2];

   int n_checks = 0;
   int n_pass   = 0;

   // Model: remaining visible strobe cycles, the code shown, accumulated lines, error tally.
   int          m_rem  [2];
   int          m_code [2];
   int          m_err  [2];
   logic [11:0] m_acc  [2];
   logic        m_errp [2];
   logic        m_took [2];

   always #5 clk = ~clk;

   priority_decoder #(.N_OUT(12), .CODE_W(4), .HOLD_CYCLES(3), .ERR_W(8)) dut3 (
      .clk(clk), .rst_n(rst_n), .in_code(code[0]), .in_valid(valid[0]), .in_ready(rdy[0]),
      .acc_clr(clr[0]), .out_onehot(oh[0]), .out_active(act[0]), .acc_vec(accv[0]),
      .err_pulse(errp[0]), .err_count(errc[0]));

   priority_decoder #(.N_OUT(12), .CODE_W(4), .HOLD_CYCLES(1), .ERR_W(8)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_code(code[1]), .in_valid(valid[1]), .in_ready(rdy[1]),
      .acc_clr(clr[1]), .out_onehot(oh[1]), .out_active(act[1]), .acc_vec(accv[1]),
      .err_pulse(errp[1]), .err_count(errc[1]));

   function automatic int hold_of(int i);
      return (i == 0) ? 3 : 1;
   endfunction

   function automatic logic [11:0] m_onehot(int i);
      logic [11:0] one;
      one = 12'd1;
      return (m_rem[i] > 0) ? (one << m_code[i]) : 12'd0;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_rem[i] = 0; m_code[i] = 0; m_err[i] = 0;
         m_acc[i] = '0; m_errp[i] = 1'b0; m_took[i] = 1'b0;
      end
   endtask

   // Advance one clock and let the model follow the same inputs.
   task automatic cycle();
      logic        take [2];
      logic        leg  [2];
      logic [11:0] one;
      one = 12'd1;
      for (int i = 0; i < 2; i++) begin
         take[i] = rst_n && valid[i] && (m_rem[i] <= 1);
         leg[i]  = (code[i] < 4'd12);
      end
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         if (clr[i]) m_acc[i] = '0;
         if (take[i] && leg[i]) m_acc[i] = m_acc[i] | (one << code[i]);
         m_errp[i] = take[i] && !leg[i];
         if (take[i] && !leg[i] && m_err[i] < 255) m_err[i]++;
         if (take[i] && leg[i]) begin
            m_code[i] = int'(code[i]);
            m_rem[i]  = hold_of(i);
         end else if (m_rem[i] > 0) begin
            m_rem[i]--;
         end
         m_took[i] = take[i];
      end
      @(negedge clk);
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         valid[i] = 1'b0; code[i] = '0; clr[i] = 1'b0;
      end
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      n_checks++; if (oh[0] !== 12'h000) $display("FAIL reset_onehot got %h want 000", oh[0]); else n_pass++;
      n_checks++; if (act[0] !== 1'b0) $display("FAIL reset_active got %b want 0", act[0]); else n_pass++;
      n_checks++; if (accv[0] !== 12'h000) $display("FAIL reset_acc got %h want 000", accv[0]); else n_pass++;
      n_checks++; if (errc[0] !== 8'd0 || errp[0] !== 1'b0) $display("FAIL reset_err got %0d/%b want 0/0", errc[0], errp[0]); else n_pass++;
      n_checks++; if (rdy[0] !== 1'b0 || rdy[1] !== 1'b0) $display("FAIL reset_ready_low got %b%b want 00", rdy[0], rdy[1]); else n_pass++;
      rst_n = 1'b1;
      #1;
      n_checks++; if (rdy[0] !== 1'b1 || rdy[1] !== 1'b1) $display("FAIL reset_ready_high got %b%b want 11", rdy[0], rdy[1]); else n_pass++;
   endtask

   task automatic test_single();
      logic [11:0] exp_oh  [5] = '{12'h020, 12'h020, 12'h020, 12'h000, 12'h000};
      logic        exp_rdy [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      code[0] = 4'd5; valid[0] = 1'b1;
      cycle();
      valid[0] = 1'b0;
      for (int k = 0; k < 5; k++) begin
         n_checks++; if (oh[0] !== exp_oh[k]) $display("FAIL single_onehot[%0d] got %h want %h", k, oh[0], exp_oh[k]); else n_pass++;
         n_checks++; if (rdy[0] !== exp_rdy[k]) $display("FAIL single_ready[%0d] got %b want %b", k, rdy[0], exp_rdy[k]); else n_pass++;
         n_checks++; if (act[0] !== (exp_oh[k] != 0)) $display("FAIL single_active[%0d] got %b", k, act[0]); else n_pass++;
         cycle();
      end
      n_checks++; if (accv[0] !== 12'h020) $display("FAIL single_acc got %h want 020", accv[0]); else n_pass++;
   endtask

   task automatic test_back_to_back();
      int          q[$];
      logic [11:0] seen[$];
      logic [11:0] exp_seq [10] = '{12'h001, 12'h001, 12'h001, 12'h800, 12'h800,
                                    12'h800, 12'h008, 12'h008, 12'h008, 12'h000};
      int          cycles;
      apply_reset();
      q = '{0, 11, 3};
      code[0] = 4'(q[0]); valid[0] = 1'b1;
      cycles = 0;
      while (cycles < 40 && !(q.size() == 0 && seen.size() >= 10)) begin
         cycle();
         cycles++;
         if (m_took[0]) begin
            void'(q.pop_front());
            if (q.size() > 0) code[0] = 4'(q[0]);
            else valid[0] = 1'b0;
         end
         if (seen.size() > 0 || oh[0] != 12'h000) seen.push_back(oh[0]);
      end
      valid[0] = 1'b0;
      n_checks++; if (seen.size() < 10) $display("FAIL b2b_length got %0d want 10", seen.size()); else n_pass++;
      for (int k = 0; k < 10 && k < seen.size(); k++) begin
         n_checks++; if (seen[k] !== exp_seq[k]) $display("FAIL b2b_onehot[%0d] got %h want %h", k, seen[k], exp_seq[k]); else n_pass++;
      end
      n_checks++; if (accv[0] !== 12'h809) $display("FAIL b2b_acc got %h want 809", accv[0]); else n_pass++;
   endtask

   task automatic test_acc_clr();
      code[0] = 4'd7; valid[0] = 1'b1; clr[0] = 1'b1;
      cycle();
      valid[0] = 1'b0; clr[0] = 1'b0;
      n_checks++; if (accv[0] !== 12'h080) $display("FAIL clr_acc got %h want 080", accv[0]); else n_pass++;
      n_checks++; if (oh[0] !== 12'h080) $display("FAIL clr_onehot got %h want 080", oh[0]); else n_pass++;
      repeat (3) cycle();
   endtask

   task automatic test_illegal();
      code[0] = 4'd13; valid[0] = 1'b1;
      cycle();
      valid[0] = 1'b0;
      n_checks++; if (errp[0] !== 1'b1) $display("FAIL illegal_pulse got %b want 1", errp[0]); else n_pass++;
      n_checks++; if (errc[0] !== 8'd1) $display("FAIL illegal_count got %0d want 1", errc[0]); else n_pass++;
      n_checks++; if (oh[0] !== 12'h000) $display("FAIL illegal_onehot got %h want 000", oh[0]); else n_pass++;
      n_checks++; if (accv[0] !== 12'h080) $display("FAIL illegal_acc got %h want 080", accv[0]); else n_pass++;
      cycle();
      n_checks++; if (errp[0] !== 1'b0) $display("FAIL illegal_pulse_width got %b want 0", errp[0]); else n_pass++;
      valid[0] = 1'b1;
      for (int k = 0; k < 300; k++) begin
         code[0] = 4'(12 + $urandom_range(0, 3));
         cycle();
      end
      valid[0] = 1'b0;
      cycle();
      n_checks++; if (errc[0] !== 8'd255) $display("FAIL illegal_saturate got %0d want 255", errc[0]); else n_pass++;
   endtask

   task automatic test_reset_mid_hold();
      code[0] = 4'd9; valid[0] = 1'b1;
      cycle();
      valid[0] = 1'b0;
      n_checks++; if (oh[0] !== 12'h200) $display("FAIL midrst_first got %h want 200", oh[0]); else n_pass++;
      @(posedge clk);
      #2;
      n_checks++; if (oh[0] !== 12'h200) $display("FAIL midrst_second got %h want 200", oh[0]); else n_pass++;
      rst_n = 1'b0;
      #1;
      n_checks++; if (oh[0] !== 12'h000 || act[0] !== 1'b0) $display("FAIL midrst_onehot got %h/%b want 000/0", oh[0], act[0]); else n_pass++;
      n_checks++; if (accv[0] !== 12'h000) $display("FAIL midrst_acc got %h want 000", accv[0]); else n_pass++;
      n_checks++; if (errc[0] !== 8'd0) $display("FAIL midrst_errcount got %0d want 0", errc[0]); else n_pass++;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      code[0] = 4'd2; valid[0] = 1'b1;
      cycle();
      valid[0] = 1'b0;
      n_checks++; if (oh[0] !== 12'h004) $display("FAIL midrst_recover got %h want 004", oh[0]); else n_pass++;
      n_checks++; if (accv[0] !== 12'h004) $display("FAIL midrst_recover_acc got %h want 004", accv[0]); else n_pass++;
      repeat (3) cycle();
   endtask

   task automatic test_full_rate();
      logic [3:0]  codes [3] = '{4'd1, 4'd2, 4'd4};
      logic [11:0] exp   [3] = '{12'h002, 12'h004, 12'h010};
      valid[1] = 1'b1;
      for (int k = 0; k < 3; k++) begin
         code[1] = codes[k];
         cycle();
         n_checks++; if (oh[1] !== exp[k]) $display("FAIL fullrate_onehot[%0d] got %h want %h", k, oh[1], exp[k]); else n_pass++;
         n_checks++; if (rdy[1] !== 1'b1) $display("FAIL fullrate_ready[%0d] got %b want 1", k, rdy[1]); else n_pass++;
      end
      valid[1] = 1'b0;
      cycle();
      n_checks++; if (oh[1] !== 12'h000) $display("FAIL fullrate_idle got %h want 000", oh[1]); else n_pass++;
   endtask

   task automatic test_random();
      for (int k = 0; k < 500; k++) begin
         for (int i = 0; i < 2; i++) begin
            valid[i] = ($urandom_range(0, 3) != 0);
            code[i]  = 4'($urandom_range(0, 15));
            clr[i]   = ($urandom_range(0, 15) == 0);
         end
         cycle();
         for (int i = 0; i < 2; i++) begin
            n_checks++; if (oh[i] !== m_onehot(i)) $display("FAIL rand_onehot[%0d] inst%0d got %h want %h", k, i, oh[i], m_onehot(i)); else n_pass++;
            n_checks++; if (act[i] !== (m_rem[i] > 0)) $display("FAIL rand_active[%0d] inst%0d got %b", k, i, act[i]); else n_pass++;
            n_checks++; if (rdy[i] !== (m_rem[i] <= 1)) $display("FAIL rand_ready[%0d] inst%0d got %b", k, i, rdy[i]); else n_pass++;
            n_checks++; if (accv[i] !== m_acc[i]) $display("FAIL rand_acc[%0d] inst%0d got %h want %h", k, i, accv[i], m_acc[i]); else n_pass++;
            n_checks++; if (errp[i] !== m_errp[i]) $display("FAIL rand_errpulse[%0d] inst%0d got %b want %b", k, i, errp[i], m_errp[i]); else n_pass++;
            n_checks++; if (errc[i] !== 8'(m_err[i])) $display("FAIL rand_errcount[%0d] inst%0d got %0d want %0d", k, i, errc[i], m_err[i]); else n_pass++;
         end
      end
      for (int i = 0; i < 2; i++) begin
         valid[i] = 1'b0; clr[i] = 1'b0;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_acc_clr();
      test_illegal();
      test_reset_mid_hold();
      test_full_rate();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
